// File: rtl/cyclic_pkg.sv
// Shared types and defaults for the serial cyclic (N,K) encoder.
package cyclic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    localparam int         CYC_N        = 7;
    localparam int         CYC_K        = 4;
    localparam logic [3:0] CYC_GEN_POLY = 4'b1011;

    function automatic int parity_w(input int n, input int k);
        return n - k;
    endfunction

endpackage

// File: rtl/cyclic_lfsr.sv
// Division-by-g(x) LFSR; with fb_en low it degenerates to a plain left shift.
module cyclic_lfsr #(
    parameter int         P        = 3,
    parameter logic [P:0] GEN_POLY = 4'b1011
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift,
    input  logic         data_in,
    input  logic         fb_en,
    output logic [P-1:0] parity
);

    logic fb;

    assign fb = fb_en & (data_in ^ parity[P-1]);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            parity <= '0;
        end else if (shift) begin
            parity[0] <= fb & GEN_POLY[0];
            for (int i = 1; i < P; i++) begin
                parity[i] <= parity[i-1] ^ (fb & GEN_POLY[i]);
            end
        end
    end

endmodule

// File: rtl/cyclic_enc_ctrl.sv
// Serial systematic cyclic encoder: message bits MSB first, then P parity bits.
// Optional parallel codeword output enabled by CYCLIC_ENC_PARALLEL_OUT_EN.
module cyclic_enc_ctrl
    import cyclic_pkg::*;
#(
    parameter int             N        = CYC_N,
    parameter int             K        = CYC_K,
    parameter logic [N-K:0]   GEN_POLY = CYC_GEN_POLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [K-1:0] in_msg,
    output logic         in_ready,
    output logic         out_valid,
    output logic         out_bit,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic [15:0]  cw_count
`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
    ,
    output logic [N-1:0] cw_par,
    output logic         cw_par_valid
`endif
);

    localparam int P     = parity_w(N, K);
    localparam int CNT_W = $clog2(((K > P) ? K : P) + 1);

    state_t             state;
    logic [K-1:0]       msg_sh;
    logic [CNT_W-1:0]   cnt;
    logic [P-1:0]       parity;
    logic               hs;
    logic               accept;

    assign accept = (state == ST_IDLE) && in_valid;
    assign hs     = out_valid && out_ready;

    cyclic_lfsr #(
        .P        (P),
        .GEN_POLY (GEN_POLY)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .shift   (hs),
        .data_in (msg_sh[K-1]),
        .fb_en   (state == ST_MSG),
        .parity  (parity)
    );

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state != ST_IDLE);
        busy      = (state != ST_IDLE);
        out_last  = (state == ST_PAR) && (cnt == CNT_W'(P - 1));
        case (state)
            ST_MSG:  out_bit = msg_sh[K-1];
            ST_PAR:  out_bit = parity[P-1];
            default: out_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            msg_sh   <= '0;
            cnt      <= '0;
            cw_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        msg_sh <= in_msg;
                        cnt    <= '0;
                        state  <= ST_MSG;
                    end
                end
                ST_MSG: begin
                    if (out_ready) begin
                        // message register shifts so its MSB is always the bit on the wire
                        msg_sh <= msg_sh << 1;
                        if (cnt == CNT_W'(K - 1)) begin
                            cnt   <= '0;
                            state <= ST_PAR;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PAR: begin
                    if (out_ready) begin
                        if (cnt == CNT_W'(P - 1)) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                            if (cw_count != 16'hFFFF) begin
                                cw_count <= cw_count + 16'd1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
    // collects the first N-1 emitted bits; the final bit joins on the last handshake
    logic [N-2:0] cw_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            cw_sh        <= '0;
            cw_par       <= '0;
            cw_par_valid <= 1'b0;
        end else begin
            cw_par_valid <= hs && out_last;
            if (hs) begin
                cw_sh <= {cw_sh[N-3:0], out_bit};
            end
            if (hs && out_last) begin
                cw_par <= {cw_sh, out_bit};
            end
        end
    end
`endif

endmodule

// File: tb/tb_cyclic_enc_ctrl.sv
// Self-checking bench for cyclic_enc_ctrl against a polynomial-division reference model.
module tb_cyclic_enc_ctrl;

    localparam int N = 7;
    localparam int K = 4;
    localparam int P = N - K;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [K-1:0] in_msg = '0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, out_bit, out_last, busy;
    logic [15:0]  cw_count;
`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
    logic [N-1:0] cw_par;
    logic         cw_par_valid;
`endif

    cyclic_enc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_msg    (in_msg),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .cw_count  (cw_count)
`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
        ,
        .cw_par       (cw_par),
        .cw_par_valid (cw_par_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: one codeword in flight at most
    bit           act = 1'b0;
    int           nb = 0;
    logic [K-1:0] cur = '0;
    int           exp_cnt = 0;
    logic [N-1:0] cap = '0;
    logic [N-1:0] last_word = '0;
    bit           pv_exp = 1'b0;
    logic [N-1:0] cwp_exp = '0;
    int           cyc = 0;
    int           acc_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // systematic codeword: msg * x^P + (msg * x^P mod g)
    function automatic logic [N-1:0] encode(input logic [K-1:0] m);
        logic [N-1:0] rem;
        logic [N-1:0] g;
        rem = {m, {P{1'b0}}};
        g   = N'(4'b1011);
        for (int i = N - 1; i >= P; i--) begin
            if (rem[i]) rem = rem ^ (g << (i - P));
        end
        return {m, rem[P-1:0]};
    endfunction

    task automatic tick(input logic r, input logic v, input logic [K-1:0] m, input logic ordy);
        logic [N-1:0] cw;
        @(negedge clk);
        cyc++;
        cw = encode(cur);
        chk("in_ready", 32'(in_ready), 32'(!act));
        chk("out_valid", 32'(out_valid), 32'(act));
        chk("busy", 32'(busy), 32'(act));
        chk("cw_count", 32'(cw_count), 32'(exp_cnt));
        if (act) begin
            chk("out_bit", 32'(out_bit), 32'(cw[N-1-nb]));
            chk("out_last", 32'(out_last), 32'(nb == N - 1));
        end else begin
            chk("out_last_idle", 32'(out_last), 32'd0);
        end
`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
        chk("cw_par_valid", 32'(cw_par_valid), 32'(pv_exp));
        chk("cw_par", 32'(cw_par), 32'(cwp_exp));
`endif
        rst       = r;
        in_valid  = v;
        in_msg    = m;
        out_ready = ordy;
        pv_exp    = 1'b0;
        if (r) begin
            act = 1'b0; nb = 0; exp_cnt = 0; cap = '0; cwp_exp = '0;
        end else if (act && ordy) begin
            cap = {cap[N-2:0], out_bit};
            nb++;
            if (nb == N) begin
                act = 1'b0;
                nb = 0;
                last_word = cap;
                if (exp_cnt != 16'hFFFF) exp_cnt++;
                pv_exp  = 1'b1;
                cwp_exp = cw;
            end
        end else if (!act && v) begin
            act = 1'b1;
            cur = m;
            nb  = 0;
            acc_q.push_back(cyc);
        end
    endtask

    // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0,1 repeating
    task automatic send(input logic [K-1:0] m, input int mode);
        int t;
        logic ordy;
        tick(1'b0, 1'b1, m, 1'b1);
        t = 0;
        while (act && t < 200) begin
            if (mode == 1) ordy = ((t % 4) == 0) || ((t % 4) == 3);
            else           ordy = 1'b1;
            tick(1'b0, 1'b0, K'($urandom), ordy);
            t++;
        end
        if (act) chk("send_timeout", 32'd1, 32'd0);
        tick(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        int base;
        int t;
        repeat (2) @(negedge clk);
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("rst_out_bit", 32'(out_bit), 32'd0);

        // abort mid-codeword after three bits
        tick(1'b0, 1'b1, 4'b1000, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 4'b1111, 1'b1);
        tick(1'b1, 1'b0, '0, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_cnt", 32'(cw_count), 32'd0);
        send(4'b0001, 0);
        chk("after_abort", 32'(last_word), 32'b0001011);

        send(4'b1000, 0);
        chk("s1000", 32'(last_word), 32'b1000101);
        chk("s1000_cnt", 32'(cw_count), 32'd2);
`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
        chk("par1000", 32'(cw_par), 32'b1000101);
`endif
        send(4'b0001, 0);
        chk("s0001", 32'(last_word), 32'b0001011);
        send(4'b1111, 0);
        chk("s1111", 32'(last_word), 32'b1111111);
        send(4'b1000, 1);
        chk("stall1000", 32'(last_word), 32'b1000101);

        // three back-to-back messages with in_valid held and in_msg churning
        acc_q.delete();
        base = exp_cnt;
        t = 0;
        while (exp_cnt < base + 3 && t < 60) begin
            tick(1'b0, 1'b1, K'($urandom), 1'b1);
            t++;
        end
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("b2b_cnt", 32'(cw_count) - 32'(base), 32'd3);
        chk("b2b_acc", 32'(acc_q.size()), 32'd3);
        for (int i = 1; i < acc_q.size(); i++) begin
            chk("b2b_gap", 32'(acc_q[i] - acc_q[i-1]), 32'd8);
        end

        for (int i = 0; i < 2000; i++) begin
            tick(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                 K'($urandom), ($urandom_range(0, 3) != 0));
        end
        tick(1'b0, 1'b0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
